// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E-stage controls and the multiply/divide unit.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; the result is computed at the start edge
// and held in p_hi/p_lo until the latency counter expires.
//   state | meaning
//   IDLE  | accepting start; MTHI/MTLO write immediately
//   RUN   | counting down latency, result pending in p_hi/p_lo
module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
    logic [WIDTH-1:0]   div_n, div_d, uq, ur, quot, rem;

    // Even op codes are the signed variants.
    always_comb begin
        a_neg = ~md.op[0] & md.a[WIDTH-1];
        b_neg = ~md.op[0] & md.b[WIDTH-1];
        a_ext = {{WIDTH{a_neg}}, md.a};
        b_ext = {{WIDTH{b_neg}}, md.b};
        prod  = a_ext * b_ext;
        if (md.op[2:1] == 2'b10) begin
            mul_res = {hi_q, lo_q} + prod;
        end else if (md.op[2:1] == 2'b11) begin
            mul_res = {hi_q, lo_q} - prod;
        end else begin
            mul_res = prod;
        end

        // Magnitude divide then re-sign; the overflow case falls out naturally.
        div_n = a_neg ? -md.a : md.a;
        div_d = b_neg ? -md.b : md.b;
        uq    = '0;
        ur    = '0;
        if (md.b == '0) begin
            quot = '1;
            rem  = md.a;
        end else begin
            uq   = div_n / div_d;
            ur   = div_n % div_d;
            quot = (a_neg ^ b_neg) ? -uq : uq;
            rem  = a_neg ? -ur : ur;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (md.start && !md.cancel) begin
                    if (!md.op[3]) begin
                        if (md.op[2:1] == 2'b01) begin
                            p_hi_d = rem;
                            p_lo_d = quot;
                            cnt_d  = CNT_W'(DIV_LAT);
                        end else begin
                            {p_hi_d, p_lo_d} = mul_res;
                            cnt_d            = CNT_W'(MULT_LAT);
                        end
                        state_d = RUN;
                    end else if (md.op[3:1] == 3'b100) begin
                        if (md.op[0]) begin
                            lo_d = md.a;
                        end else begin
                            hi_d = md.a;
                        end
                    end
                end
            end
            RUN: begin
                if (md.cancel) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_d    = p_hi_q;
                        lo_d    = p_lo_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign md.busy = (state_q == RUN);
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit that holds the HI/LO registers for the pipelined MIPS core. It sits in the execute stage beside the ALU, is driven by the E-stage start/op controls, and reports `busy` so the hazard controller stalls HI/LO-dependent instructions. It generalises the fixed multiply/divide unit in four ways:
- configurable width and latencies;
- accumulate modes (MADD/MSUB);
- a flush/cancel input;
- a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MULT_LAT`, 5: busy cycles for MULT/MULTU/MADD*/MSUB* (legal range ≥1).
- `DIV_LAT`, 10: busy cycles for DIV/DIVU (legal range ≥1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the operation selected by `op`; sampled only when not busy.
- `op`  in  4  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU;
  - 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU;
  - 8 MTHI, 9 MTLO;
  - 10–15 no-op.
- `a`  in  `WIDTH`  rs operand (forwarded value).
- `b`  in  `WIDTH`  rt operand (forwarded value).
- `cancel`  in  1  abort the in-flight operation (exception/flush).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse in the first cycle new HI/LO is visible.
- `hi`  out  `WIDTH`  HI register.
- `lo`  out  `WIDTH`  LO register.

## Operation
- **State machine:** IDLE, RUN.
  - Counter `cnt` of width clog2(max(MULT_LAT, DIV_LAT)) + 1.
  - Pending registers `p_hi` and `p_lo`.
- **IDLE, `start`=1 with op 0–7:**
  - Compute the result from `a`/`b` at this edge and latch it into `p_hi`/`p_lo`.
  - Load `cnt` with the op's latency, go to RUN.
- **IDLE, `start`=1 with op 8/9:** write `a` into HI (8) or LO (9) at this edge. Stay in IDLE, no `busy`, no `done`.
- **IDLE, op 10–15 or `start`=0:** nothing happens.
- **RUN:** `cnt` decrements each cycle. When `cnt`=1 at an edge:
  - HI←`p_hi`, LO←`p_lo`;
  - go to IDLE;
  - `done`=1 in the following cycle.
- **Multiply results** (2·`WIDTH` product P, split {HI,LO}):
  - MULT/MULTU: {HI,LO}=P (signed or unsigned).
  - MADD*: {HI,LO}+=P.
  - MSUB*: {HI,LO}−=P.
  - All arithmetic is modulo 2^(2·`WIDTH`). Accumulate ops use the HI/LO value at the start edge.
- **Divide results:**
  - LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: LO=all ones, HI=`a`. No trap.
  - Signed overflow (−2^(`WIDTH`−1) / −1): LO=−2^(`WIDTH`−1), HI=0.
- **`start` while RUN:** ignored entirely, including op 8/9. The controller must stall; it forms stall = `busy` | (`start` & E-stage md op).
- **`cancel`:**
  - In RUN: return to IDLE at the next edge; HI/LO unchanged, `done` never pulses.
  - In IDLE: suppresses a simultaneous `start`, including MTHI/MTLO.
- **`reset`:** overrides everything, including mid-RUN. At the next edge: HI=LO=0, `busy`=0, `done`=0, `cnt`=0, `p_hi`=`p_lo`=0, state IDLE.

## Timing
- Latency: `start` high in cycle 0 → `busy`=1 in cycles 1..L → `busy`=0, `done`=1, new HI/LO visible in cycle L+1.
- L = `MULT_LAT` or `DIV_LAT` depending on op.
- MTHI/MTLO: new value visible in cycle 1.
- Back-to-back: a new `start` is accepted in cycle L+1, i.e. the same cycle `done` is high; `busy` then rises again in cycle L+2. An accumulate op started in cycle L+1 uses the just-written HI/LO.
- `busy`, `done`, `hi` and `lo` are all registered; there are no combinational input→output paths.
- `cancel` in cycle k of RUN → `busy`=0 in cycle k+1.

## Test plan
- **Reset:** assert `reset` 2 cycles, including once mid-DIV → hi=lo=0, busy=0, done=0.
- **MULT:** a=0xFFFFFFFE (−2), b=3, defaults → busy cycles 1–5; cycle 6: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1. The same operands with MULTU give hi=0x00000002, lo=0xFFFFFFFA.
- **DIV, DIVU, divide by zero:**
  - DIV a=−7, b=2 → busy cycles 1–10; cycle 11: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=7.
- **MADD then MSUB:**
  - MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0.
  - Then MSUB a=1, b=1 → hi=0, lo=0xFFFFFFFF.
- **Cancel:** MULT started, `cancel` in cycle 3 → busy=0 in cycle 4; hi/lo keep their pre-start values; done stays 0.
- **Start while busy:**
  - `start`+MTLO a=0x1234 during a DIV → ignored, lo ends with the quotient.
  - Then, with parameters MULT_LAT=1, DIV_LAT=1, DIV then MULT on consecutive accepted starts → busy 1 cycle each, done pulses in cycles 2 and 4.
